// File: rtl/tage_trace_sequencer.sv
// Buffers branch trace records in a small FIFO and replays each one through the
// TAGE predictor phases (index/tag, table read, compare settle, predict, update).
module tage_trace_sequencer #(
    parameter int unsigned ADDRESS_SIZE = 32,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned COUNT_W      = 32
) (
    input  logic                          CLK,
    input  logic                          reset,
    input  logic                          trace_valid,
    output logic                          trace_ready,
    input  logic [ADDRESS_SIZE-1:0]       trace_pc,
    input  logic                          trace_taken,
    input  logic                          run,
    input  logic                          flush,
    output logic [ADDRESS_SIZE-1:0]       pc,
    output logic                          Actual_branch,
    output logic                          index_tag_enable,
    output logic                          table_read_en,
    output logic                          update_predictor_enable,
    output logic                          update_enable,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [COUNT_W-1:0]            branches_issued
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned REC_W = ADDRESS_SIZE + 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_IDX  = 3'd1,
        S_RD   = 3'd2,
        S_CMP  = 3'd3,
        S_PRD  = 3'd4,
        S_UPD  = 3'd5
    } state_e;

    state_e                    state_q, state_d;
    logic [REC_W-1:0]          mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]          count_q, count_d;
    logic                      ready_q, ready_d;
    logic [ADDRESS_SIZE-1:0]   pc_q, pc_d;
    logic                      taken_q, taken_d;
    logic                      idx_q, idx_d;
    logic                      rd_q, rd_d;
    logic                      prd_q, prd_d;
    logic                      upd_q, upd_d;
    logic                      busy_q, busy_d;
    logic [COUNT_W-1:0]        issued_q, issued_d;
    logic                      push;
    logic                      pop;
    logic [REC_W-1:0]          head;

    // Next-state: FIFO bookkeeping, phase sequencing and strobes decoded from the next phase.
    always_comb begin
        push     = trace_valid && ready_q && !flush;
        pop      = ((state_q == S_IDLE) || (state_q == S_UPD)) && run
                   && (count_q != '0) && !flush;
        head     = mem_q[rd_ptr_q];
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        pc_d     = pc_q;
        taken_d  = taken_q;
        issued_d = issued_q;

        unique case (state_q)
            S_IDLE:  if (pop) state_d = S_IDX;
            S_IDX:   state_d = S_RD;
            S_RD:    state_d = S_CMP;
            S_CMP:   state_d = S_PRD;
            S_PRD:   state_d = S_UPD;
            S_UPD:   state_d = pop ? S_IDX : S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (state_q == S_UPD) begin
            issued_d = issued_q + COUNT_W'(1);
        end

        // Flush empties the buffer but never cuts short a sequence already under way.
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
                pc_d     = head[ADDRESS_SIZE-1:0];
                taken_d  = head[ADDRESS_SIZE];
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end

        ready_d = (count_d < CNT_W'(FIFO_DEPTH));
        idx_d   = (state_d == S_IDX);
        rd_d    = (state_d == S_RD);
        prd_d   = (state_d == S_PRD);
        upd_d   = (state_d == S_UPD);
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
            pc_q     <= '0;
            taken_q  <= 1'b0;
            idx_q    <= 1'b0;
            rd_q     <= 1'b0;
            prd_q    <= 1'b0;
            upd_q    <= 1'b0;
            busy_q   <= 1'b0;
            issued_q <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
            pc_q     <= pc_d;
            taken_q  <= taken_d;
            idx_q    <= idx_d;
            rd_q     <= rd_d;
            prd_q    <= prd_d;
            upd_q    <= upd_d;
            busy_q   <= busy_d;
            issued_q <= issued_d;
        end
    end

    // Record storage needs no reset; validity is tracked by the pointers and count.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {trace_taken, trace_pc};
        end
    end

    assign trace_ready             = ready_q;
    assign pc                      = pc_q;
    assign Actual_branch           = taken_q;
    assign index_tag_enable        = idx_q;
    assign table_read_en           = rd_q;
    assign update_predictor_enable = prd_q;
    assign update_enable           = upd_q;
    assign busy                    = busy_q;
    assign fifo_count              = count_q;
    assign branches_issued         = issued_q;

endmodule

// File: tb/tb_tage_trace_sequencer.sv
// Self-checking bench for tage_trace_sequencer: directed vector table, corner-case
// sequences and random traffic compared against a queue-based behavioural model.
module tb_tage_trace_sequencer;

    logic        CLK = 1'b0;
    logic        reset;
    logic        trace_valid;
    logic        trace_ready;
    logic [31:0] trace_pc;
    logic        trace_taken;
    logic        run;
    logic        flush;
    logic [31:0] pc;
    logic        Actual_branch;
    logic        index_tag_enable, table_read_en, update_predictor_enable, update_enable;
    logic        busy;
    logic [2:0]  fifo_count;
    logic [31:0] branches_issued;

    logic        s_ready, s_act, s_idx, s_rd, s_prd, s_upd, s_busy;
    logic [31:0] s_pc;
    logic [2:0]  s_cnt;
    logic [1:0]  s_iss;

    tage_trace_sequencer dut (
        .CLK(CLK), .reset(reset), .trace_valid(trace_valid), .trace_ready(trace_ready),
        .trace_pc(trace_pc), .trace_taken(trace_taken), .run(run), .flush(flush),
        .pc(pc), .Actual_branch(Actual_branch), .index_tag_enable(index_tag_enable),
        .table_read_en(table_read_en), .update_predictor_enable(update_predictor_enable),
        .update_enable(update_enable), .busy(busy), .fifo_count(fifo_count),
        .branches_issued(branches_issued)
    );

    // Narrow-counter twin sharing all stimulus, used to observe counter wrap-around.
    tage_trace_sequencer #(.COUNT_W(2)) dut_w2 (
        .CLK(CLK), .reset(reset), .trace_valid(trace_valid), .trace_ready(s_ready),
        .trace_pc(trace_pc), .trace_taken(trace_taken), .run(run), .flush(flush),
        .pc(s_pc), .Actual_branch(s_act), .index_tag_enable(s_idx),
        .table_read_en(s_rd), .update_predictor_enable(s_prd),
        .update_enable(s_upd), .busy(s_busy), .fifo_count(s_cnt),
        .branches_issued(s_iss)
    );

    always #5 CLK = ~CLK;

    logic [3:0] strb;
    assign strb = {index_tag_enable, table_read_en, update_predictor_enable, update_enable};

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] pc;
        logic        tk;
    } rec_t;

    rec_t        m_q[$];
    int          m_phase;
    logic [31:0] m_pc;
    logic        m_tk;
    logic [31:0] m_issued;
    logic        m_ready;
    logic        m_rst;
    logic        m_pushed;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_phase  = 0;
        m_pc     = '0;
        m_tk     = 1'b0;
        m_issued = '0;
        m_ready  = 1'b0;
        m_pushed = 1'b0;
    endtask

    // Branch position 0 = idle, 1..5 = IDX, RD, CMP, PRD, UPD.
    task automatic model_edge();
        logic do_push, do_pop;
        m_pushed = 1'b0;
        if (m_rst) return;
        do_push = trace_valid && m_ready && !flush;
        do_pop  = (m_phase == 0 || m_phase == 5) && run && (m_q.size() > 0) && !flush;
        if (m_phase == 5) m_issued = m_issued + 1;
        if (flush) begin
            m_q.delete();
        end else begin
            if (do_pop) begin
                m_pc = m_q[0].pc;
                m_tk = m_q[0].tk;
                void'(m_q.pop_front());
            end
            if (do_push) begin
                m_q.push_back('{pc: trace_pc, tk: trace_taken});
                m_pushed = 1'b1;
            end
        end
        if (do_pop)            m_phase = 1;
        else if (m_phase == 5) m_phase = 0;
        else if (m_phase > 0)  m_phase = m_phase + 1;
        m_ready = (m_q.size() < 4);
    endtask

    function automatic logic [3:0] exp_strb(input int ph);
        case (ph)
            1:       return 4'b1000;
            2:       return 4'b0100;
            4:       return 4'b0010;
            5:       return 4'b0001;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic check_model();
        chk("ready", 64'(trace_ready), 64'(m_ready));
        chk("count", 64'(fifo_count), 64'(m_q.size()));
        chk("strobes", 64'(strb), 64'(exp_strb(m_phase)));
        chk("busy", 64'(busy), 64'(m_phase != 0));
        chk("pc", 64'(pc), 64'(m_pc));
        chk("actual", 64'(Actual_branch), 64'(m_tk));
        chk("issued", 64'(branches_issued), 64'(m_issued));
        chk("issued_w2", 64'(s_iss), 64'(m_issued[1:0]));
    endtask

    task automatic tick();
        @(posedge CLK);
        model_edge();
        #1;
        check_model();
    endtask

    typedef struct {
        logic        v;
        logic [31:0] p;
        logic        t;
        logic        r;
        logic [3:0]  strb;
        logic        bsy;
        logic [2:0]  cnt;
        logic [31:0] epc;
        logic        etk;
        logic [31:0] iss;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int          idx;
        int          nb;
        int          ncmp_idle;
        int          got5;
        int          ord;
        logic [31:0] iss0;
        logic        wrap_seen;

        // Single branch: push at edge 0, phases on following edges, counter bumps leaving UPD.
        tbl[0] = '{1'b1, 32'h0000_1234, 1'b1, 1'b1, 4'b0000, 1'b0, 3'd1, 32'h0, 1'b0, 32'd0};
        tbl[1] = '{1'b0, 32'h0, 1'b0, 1'b1, 4'b1000, 1'b1, 3'd0, 32'h1234, 1'b1, 32'd0};
        tbl[2] = '{1'b0, 32'h0, 1'b0, 1'b1, 4'b0100, 1'b1, 3'd0, 32'h1234, 1'b1, 32'd0};
        tbl[3] = '{1'b0, 32'h0, 1'b0, 1'b1, 4'b0000, 1'b1, 3'd0, 32'h1234, 1'b1, 32'd0};
        tbl[4] = '{1'b0, 32'h0, 1'b0, 1'b1, 4'b0010, 1'b1, 3'd0, 32'h1234, 1'b1, 32'd0};
        tbl[5] = '{1'b0, 32'h0, 1'b0, 1'b1, 4'b0001, 1'b1, 3'd0, 32'h1234, 1'b1, 32'd0};
        tbl[6] = '{1'b0, 32'h0, 1'b0, 1'b1, 4'b0000, 1'b0, 3'd0, 32'h1234, 1'b1, 32'd1};

        reset = 1'b0; trace_valid = 1'b0; trace_pc = '0; trace_taken = 1'b0;
        run = 1'b0; flush = 1'b0;
        m_rst = 1'b1;
        model_reset();
        #12;
        check_model();
        chk("rst_ready", 64'(trace_ready), 64'd0);

        reset = 1'b1;
        m_rst = 1'b0;
        tick();
        chk("ready_after_rst", 64'(trace_ready), 64'd1);

        for (int i = 0; i < 7; i++) begin
            trace_valid = tbl[i].v; trace_pc = tbl[i].p; trace_taken = tbl[i].t; run = tbl[i].r;
            tick();
            chk($sformatf("vec%0d_strb", i), 64'(strb), 64'(tbl[i].strb));
            chk($sformatf("vec%0d_busy", i), 64'(busy), 64'(tbl[i].bsy));
            chk($sformatf("vec%0d_cnt", i), 64'(fifo_count), 64'(tbl[i].cnt));
            chk($sformatf("vec%0d_pc", i), 64'(pc), 64'(tbl[i].epc));
            chk($sformatf("vec%0d_tk", i), 64'(Actual_branch), 64'(tbl[i].etk));
            chk($sformatf("vec%0d_iss", i), 64'(branches_issued), 64'(tbl[i].iss));
        end

        // Fill beyond depth with run low, then drain back-to-back.
        run = 1'b0; idx = 0;
        for (int c = 0; c < 6; c++) begin
            trace_valid = 1'b1; trace_pc = 32'h100 + 32'(idx); trace_taken = idx[0];
            tick();
            if (m_pushed) idx++;
        end
        chk("full_accepted", 64'(idx), 64'd4);
        chk("full_cnt", 64'(fifo_count), 64'd4);
        chk("full_ready", 64'(trace_ready), 64'd0);
        run = 1'b1; nb = 0; ncmp_idle = 0; got5 = -1; ord = 0; wrap_seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (m_pushed) begin
                idx++;
                if (idx == 5) got5 = c;
            end
            if (busy) nb++;
            if (busy && strb == 4'b0000) ncmp_idle++;
            if (index_tag_enable) begin
                chk($sformatf("order%0d", ord), 64'(pc), 64'(32'h100 + 32'(ord)));
                ord++;
            end
            if (m_issued == 32'd4 && !wrap_seen) begin
                chk("wrap_w2", 64'(s_iss), 64'd0);
                wrap_seen = 1'b1;
            end
            if (idx < 5) begin
                trace_pc = 32'h100 + 32'(idx); trace_taken = idx[0];
            end else begin
                trace_valid = 1'b0;
            end
            if (!busy && nb > 0) break;
        end
        chk("stream_busy_cycles", 64'(nb), 64'd25);
        chk("stream_cmp_cycles", 64'(ncmp_idle), 64'd5);
        chk("fifth_accept_cycle", 64'(got5), 64'd1);
        chk("stream_issued", 64'(branches_issued), 64'd6);
        chk("wrap_seen", 64'(wrap_seen), 64'd1);

        // Flush while the first of four buffered branches is in RD.
        run = 1'b0;
        for (int k = 0; k < 4; k++) begin
            trace_valid = 1'b1; trace_pc = 32'h200 + 32'(k); trace_taken = 1'b1;
            tick();
        end
        trace_valid = 1'b0; run = 1'b1;
        iss0 = branches_issued;
        tick();
        tick();
        chk("flush_in_rd", 64'(table_read_en), 64'd1);
        chk("flush_cnt_before", 64'(fifo_count), 64'd3);
        flush = 1'b1; trace_valid = 1'b1; trace_pc = 32'hDEAD;
        tick();
        flush = 1'b0; trace_valid = 1'b0;
        chk("flush_cnt", 64'(fifo_count), 64'd0);
        for (int k = 0; k < 3; k++) tick();
        chk("flush_idle", 64'(busy), 64'd0);
        chk("flush_issued", 64'(branches_issued), 64'(iss0 + 32'd1));
        chk("flush_pc", 64'(pc), 64'h200);

        // Asynchronous reset during PRD.
        trace_valid = 1'b1; trace_pc = 32'h300; trace_taken = 1'b0;
        tick();
        trace_valid = 1'b0;
        for (int k = 0; k < 10 && m_phase != 4; k++) tick();
        chk("reached_prd", 64'(update_predictor_enable), 64'd1);
        #3;
        reset = 1'b0; m_rst = 1'b1; model_reset();
        #1;
        chk("arst_strobes", 64'(strb), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_cnt", 64'(fifo_count), 64'd0);
        check_model();
        tick();
        tick();
        reset = 1'b1; m_rst = 1'b0;
        tick();
        trace_valid = 1'b1; trace_pc = 32'h400; trace_taken = 1'b1;
        tick();
        trace_valid = 1'b0;
        for (int k = 0; k < 7; k++) tick();
        chk("post_rst_issued", 64'(branches_issued), 64'd1);
        chk("post_rst_pc", 64'(pc), 64'h400);

        // Random traffic against the model.
        for (int c = 0; c < 600; c++) begin
            trace_valid = ($urandom_range(1) == 1);
            trace_pc    = $urandom;
            trace_taken = $urandom_range(1) == 1;
            run         = ($urandom_range(3) != 0);
            flush       = ($urandom_range(19) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
